uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART byte receiver. It generates the baud-rate enable that paces the receiver FSM and captures each completed byte. It screens bytes on parity status and buffers them in a small FIFO. Bytes go to the consumer over a valid/ready interface, with sticky overflow and saturating parity-error statistics.

Parameters:
BAUD_DIV, 868, clk cycles per bit period (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, byte slots; power of two, 2..16
DROP_ERR, 1, 1 = discard bytes flagged with a parity error; 0 = buffer them anyway

Ports:
clk  in  1  system clock, all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = receive path running
clear  in  1  synchronous pulse; zeroes overflow and perr_count
baud_tick  out  1  one-cycle bit-rate enable to the receiver
rx_byte  in  8  received byte from the receiver
rx_done  in  1  one-cycle strobe: rx_byte/rx_perr are valid this cycle
rx_perr  in  1  parity error for the byte qualified by rx_done
m_data  out  8  FIFO head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid & m_ready
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky; a byte was lost because the FIFO was full
perr_count  out  8  parity-error count, saturates at 255
busy  out  1  state != OFF

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=OFF; baud counter=0; FIFO empty.
  - baud_tick=0, m_valid=0, m_data=0, fifo_count=0, overflow=0, perr_count=0, busy=0.
  - Reset mid-frame or mid-drain discards all buffered bytes.
- FSM states:
  - OFF -> RUN when enable=1.
  - RUN -> DRAIN when enable=0 and FIFO non-empty; RUN -> OFF when enable=0 and FIFO empty.
  - DRAIN -> OFF when FIFO becomes empty (pop of the last byte); DRAIN -> RUN if enable returns to 1.
- Baud generator:
  - 16-bit counter runs only in RUN; cleared to 0 on entry to RUN and in OFF/DRAIN.
  - Counts 0..BAUD_DIV-1 and wraps.
  - baud_tick=1 for exactly one cycle when count==BAUD_DIV-1, so the first tick comes BAUD_DIV cycles after entering RUN.
- Capture:
  - rx_done is honoured only in RUN; it is ignored in OFF and DRAIN.
  - Every honoured rx_done with rx_perr=1 increments perr_count (saturating), whatever DROP_ERR is set to.
  - push = honoured rx_done & !(rx_perr & DROP_ERR).
- FIFO:
  - First-word-fall-through. m_data reflects the head combinationally from storage; it holds its last value when empty.
  - Latency: push in cycle N -> m_valid=1 and m_data=byte in cycle N+1.
  - pop = m_valid & m_ready; m_ready while empty has no effect.
  - Push while full and no pop: byte discarded, overflow<=1, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (m_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- clear:
  - Zeroes overflow and perr_count next cycle; FIFO contents are untouched.
  - clear wins over a simultaneous overflow or parity event, and that event is not recorded.
- Outputs are registered, except m_data/m_valid, which come from FIFO storage/count registers with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (OFF, RUN, DRAIN).
  - Default constants: BAUD_DIV_115200=868, BYTE_W=8.
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, FWFT). uart_rx_ctrl instantiates it with WIDTH=8.
- Baud generator and statistics stay inline.

Test Plan:
- Tick spacing: BAUD_DIV=10, enable=1 after reset -> baud_tick pulses first at cycle 10 after entering RUN, then every 10 cycles; enable=0 -> no further ticks.
- Basic path: rx_done with rx_byte=0x41, rx_perr=0 -> next cycle m_valid=1, m_data=0x41, fifo_count=1; m_ready=1 -> m_valid=0, fifo_count=0.
- Parity screening:
  - DROP_ERR=1: rx_byte=0x55, rx_perr=1 -> not buffered, perr_count=1.
  - DROP_ERR=0: same stimulus -> 0x55 buffered, perr_count=1.
- Overflow and clear, FIFO_DEPTH=4, m_ready=0:
  - Push 0x01..0x05 -> fifo_count=4, overflow=1, pops yield 0x01..0x04.
  - Push while full with m_ready=1 in the same cycle -> no overflow, count stays 4.
  - clear -> overflow=0.
- Drain: 3 bytes buffered, enable=0 -> state DRAIN, busy=1, no ticks, a new rx_done is ignored; after 3 pops -> OFF, busy=0.
- Async reset: assert reset_n=0 mid-drain with 2 bytes buffered -> all outputs zero immediately, without waiting for a clock edge; release -> OFF, FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller.
//   state_e         : controller state encoding (OFF, RUN, DRAIN)
//   BAUD_DIV_115200 : clk cycles per bit at 100 MHz / 115200 baud
//   BYTE_W          : received byte width
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BAUD_DIV_115200 = 868;
  localparam int BYTE_W          = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte path between receiver, controller and consumer.
//   rx_byte/rx_done/rx_perr : byte and strobe from the bit-level receiver
//   m_data/m_valid/m_ready  : valid/ready stream towards the consumer
// master: the controller (consumes rx_*, drives the stream)
// slave : the receiver/consumer side
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int W = BYTE_W
);
  logic [W-1:0] rx_byte;
  logic         rx_done;
  logic         rx_perr;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (
    input  rx_byte, rx_done, rx_perr, m_ready,
    output m_data, m_valid
  );

  modport slave (
    output rx_byte, rx_done, rx_perr, m_ready,
    input  m_data, m_valid
  );
endinterface

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   push_i/data_i : write request and data (ignored when full unless popping)
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry; holds the last popped entry while empty
//   full_o/empty_o/count_o : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // When full, a push is only accepted if the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // While empty, the slot just behind the read pointer is the last byte handed
  // out, so the output holds steady without an extra register.
  assign data_o = empty_o ? mem_q[rd_q - AW'(1)] : mem_q[rd_q];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: baud enable generation, byte capture with
// parity screening, FWFT buffering and error statistics.
//   clk, reset_n      : clock and async active-low reset
//   enable            : receive path on/off (level)
//   clear             : sync pulse, zeroes overflow and perr_count
//   baud_tick         : one-cycle bit-rate enable
//   bus (master)      : rx_byte/rx_done/rx_perr in, m_data/m_valid/m_ready stream
//   fifo_count        : FIFO occupancy
//   overflow          : sticky, a byte was lost to a full FIFO
//   perr_count        : saturating parity-error count
//   busy              : controller not OFF
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_115200,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_ERR   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  output logic                          baud_tick,
  uart_rx_ctrl_if.master                bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    perr_count,
  output logic                          busy
);
  localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        tick_q, ovf_q;
  logic [7:0]  perr_q;

  logic honoured, perr_ev, push, pop, full, empty, last_out, remain;

  assign honoured = (state_q == ST_RUN) && bus.rx_done;
  assign perr_ev  = honoured && bus.rx_perr;
  assign push     = honoured && !(bus.rx_perr && (DROP_ERR != 0));
  assign pop      = bus.m_valid && bus.m_ready;
  assign last_out = pop && (fifo_count == CW'(1));
  // FIFO still holds something after this cycle's push/pop.
  assign remain   = push || (!empty && !last_out);

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (bus.rx_byte),
    .pop_i   (pop),
    .data_o  (bus.m_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign bus.m_valid = !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= '0;
    end else begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
      case (state_q)
        ST_OFF: begin
          if (enable) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= remain ? ST_DRAIN : ST_OFF;
          end else begin
            // Tick is registered off the terminal count, so the first one
            // lands BAUD_DIV cycles after entering RUN.
            cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
            tick_q <= (cnt_q == LAST);
          end
        end
        ST_DRAIN: begin
          if (enable)       state_q <= ST_RUN;
          else if (!remain) state_q <= ST_OFF;
        end
        default: state_q <= ST_OFF;
      endcase

      if (clear) begin
        ovf_q  <= 1'b0;
        perr_q <= '0;
      end else begin
        if (push && full && !pop)        ovf_q  <= 1'b1;
        if (perr_ev && perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
      end
    end
  end

  assign baud_tick  = tick_q;
  assign overflow   = ovf_q;
  assign perr_count = perr_q;
  assign busy       = (state_q != ST_OFF);

endmodule
